// File: rtl/coin_dispenser.sv
// Change/refund dispenser: pays a nickel-unit amount as one-cycle dime/nickel pulses, dimes first.
// Optional COIN_DISPENSER_HOLD_EN adds a hold input that freezes dispensing while in ISSUE or GAP.
module coin_dispenser #(
  parameter int AMT_W      = 5,
  parameter int GAP_CYCLES = 1,
  parameter int DIME_STOCK = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill,
`ifdef COIN_DISPENSER_HOLD_EN
  input  logic             hold,
`endif
  output logic             busy,
  output logic             n,
  output logic             d,
  output logic             done,
  output logic             dime_empty
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, FIN} state_t;

  localparam int              GW         = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [7:0]      STOCK_INIT = 8'(DIME_STOCK);
  localparam logic [GW-1:0]   GAP_INIT   = GW'(GAP_CYCLES);

  state_t           state, state_nx;
  logic [AMT_W-1:0] rem, rem_nx;
  logic [7:0]       stock, stock_nx;
  logic [GW-1:0]    gap_cnt, gap_nx;
  logic             give_dime, give_nickel;
  logic             busy_nx, n_nx, d_nx, done_nx, dime_empty_nx;
  logic             frozen;

`ifdef COIN_DISPENSER_HOLD_EN
  assign frozen = hold && (state == ISSUE || state == GAP);
`else
  assign frozen = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      rem        <= '0;
      stock      <= STOCK_INIT;
      gap_cnt    <= '0;
      busy       <= 1'b0;
      n          <= 1'b0;
      d          <= 1'b0;
      done       <= 1'b0;
      dime_empty <= (STOCK_INIT == 8'd0);
    end else begin
      state      <= state_nx;
      rem        <= rem_nx;
      stock      <= stock_nx;
      gap_cnt    <= gap_nx;
      busy       <= busy_nx;
      n          <= n_nx;
      d          <= d_nx;
      done       <= done_nx;
      dime_empty <= dime_empty_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    rem_nx      = rem;
    stock_nx    = stock;
    gap_nx      = gap_cnt;
    give_dime   = 1'b0;
    give_nickel = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          rem_nx   = amount;
          state_nx = (amount == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        if (!frozen) begin
          // a dime is only taken with remaining>=2, so remaining cannot underflow
          if (rem >= AMT_W'(2) && stock != 8'd0) begin
            give_dime = 1'b1;
            rem_nx    = rem - AMT_W'(2);
            stock_nx  = stock - 8'd1;
          end else begin
            give_nickel = 1'b1;
            rem_nx      = rem - AMT_W'(1);
          end
          if (rem_nx == '0) begin
            state_nx = FIN;
          end else if (GAP_CYCLES > 0) begin
            state_nx = GAP;
            gap_nx   = GAP_INIT;
          end
        end
      end
      GAP: begin
        if (!frozen) begin
          gap_nx = gap_cnt - GW'(1);
          if (gap_cnt <= GW'(1)) state_nx = ISSUE;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (refill) stock_nx = STOCK_INIT;
  end

  // Output values are decided here and registered alongside the state.
  always_comb begin
    busy_nx       = (state != IDLE);
    n_nx          = give_nickel;
    d_nx          = give_dime;
    done_nx       = (state == FIN);
    dime_empty_nx = (stock == 8'd0);
  end

endmodule

// File: tb/tb_coin_dispenser.sv
// Directed bench for coin_dispenser with GAP_CYCLES=1, DIME_STOCK=2.
module tb_coin_dispenser;
  logic       clk = 1'b0;
  logic       reset, start, refill;
  logic [4:0] amount;
  logic       busy, n, d, done, dime_empty;
  int         checks = 0;
  int         errors = 0;

  coin_dispenser #(.AMT_W(5), .GAP_CYCLES(1), .DIME_STOCK(2)) dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount), .refill(refill),
`ifdef COIN_DISPENSER_HOLD_EN
    .hold(1'b0),
`endif
    .busy(busy), .n(n), .d(d), .done(done), .dime_empty(dime_empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // code: 0 quiet, 1 nickel, 2 dime, 3 done; busy expected high
  function automatic logic [3:0] code2v(int c);
    return {c == 1, c == 2, c == 3, 1'b1};
  endfunction

  task automatic start_req(input logic [4:0] a);
    start = 1'b1; amount = a;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; amount = 5'd3; refill = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({n, d, done, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outs cycle %0d: got ndDb=%b want 0000", k, {n, d, done, busy});
      end
    end
    reset = 1'b1; start = 1'b0;
    tick();
    checks++;
    if ({dime_empty, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: got dime_empty,busy=%b want 00", {dime_empty, busy});
    end
  endtask

  task automatic test_amount3();
    int e[4];
    int total = 0;
    e = '{2, 0, 1, 3};
    start_req(5'd3);
    for (int k = 0; k < 4; k++) begin
      tick();
      total += n * 5 + d * 10;
      checks++;
      if ({n, d, done, busy} !== code2v(e[k])) begin
        errors++;
        $display("FAIL amt3 t+%0d: got ndDb=%b want %b", k + 1, {n, d, done, busy}, code2v(e[k]));
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || total != 15) begin
      errors++;
      $display("FAIL amt3_end: got busy=%b total=%0d want busy=0 total=15", busy, total);
    end
  endtask

  task automatic test_zero();
    start_req(5'd0);
    tick();
    checks++;
    if ({n, d, done, busy} !== 4'b0011) begin
      errors++;
      $display("FAIL zero t+1: got ndDb=%b want 0011", {n, d, done, busy});
    end
    tick();
    checks++;
    if ({n, d, done, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL zero t+2: got ndDb=%b want 0000", {n, d, done, busy});
    end
  endtask

  task automatic test_exhaust();
    int e[8];
    int f[4];
    logic de_exp;
    e = '{2, 0, 2, 0, 1, 0, 1, 3};
    f = '{1, 0, 1, 3};
    refill = 1'b1; tick(); refill = 1'b0; tick();
    start_req(5'd6);
    for (int k = 0; k < 8; k++) begin
      tick();
      de_exp = (k + 1 >= 4);
      checks++;
      if ({n, d, done, busy, dime_empty} !== {code2v(e[k]), de_exp}) begin
        errors++;
        $display("FAIL exhaust t+%0d: got ndDbE=%b want %b", k + 1,
                 {n, d, done, busy, dime_empty}, {code2v(e[k]), de_exp});
      end
    end
    tick();
    start_req(5'd2);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({n, d, done, busy, dime_empty} !== {code2v(f[k]), 1'b1}) begin
        errors++;
        $display("FAIL empty_amt2 t+%0d: got ndDbE=%b want %b", k + 1,
                 {n, d, done, busy, dime_empty}, {code2v(f[k]), 1'b1});
      end
    end
    tick();
  endtask

  task automatic test_refill();
    int e[4];
    e = '{2, 0, 2, 3};
    refill = 1'b1; tick(); refill = 1'b0; tick();
    checks++;
    if (dime_empty !== 1'b0) begin
      errors++;
      $display("FAIL refill_clear: got dime_empty=%b want 0", dime_empty);
    end
    start_req(5'd4);
    for (int k = 0; k < 4; k++) begin
      tick();
      refill = (k == 1);  // sampled on the edge of the second dime
      checks++;
      if ({n, d, done, busy, dime_empty} !== {code2v(e[k]), 1'b0}) begin
        errors++;
        $display("FAIL refill_amt4 t+%0d: got ndDbE=%b want %b", k + 1,
                 {n, d, done, busy, dime_empty}, {code2v(e[k]), 1'b0});
      end
    end
    refill = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (dime_empty !== 1'b0) begin
        errors++;
        $display("FAIL refill_coincident: got dime_empty=%b want 0", dime_empty);
      end
    end
  endtask

  task automatic test_busy_start();
    int e[6];
    int total = 0;
    e = '{2, 0, 2, 0, 1, 3};
    start_req(5'd5);
    for (int k = 0; k < 6; k++) begin
      tick();
      total += n * 5 + d * 10;
      if (k == 0) begin start = 1'b1; amount = 5'd1; end
      else start = 1'b0;
      checks++;
      if ({n, d, done, busy} !== code2v(e[k])) begin
        errors++;
        $display("FAIL busy_start t+%0d: got ndDb=%b want %b", k + 1, {n, d, done, busy}, code2v(e[k]));
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || total != 25) begin
      errors++;
      $display("FAIL busy_start_end: got busy=%b total=%0d want busy=0 total=25", busy, total);
    end
  endtask

  task automatic test_reset_abort();
    refill = 1'b1; tick(); refill = 1'b0; tick();
    start_req(5'd5);
    tick();
    checks++;
    if ({n, d, done, busy} !== 4'b0101) begin
      errors++;
      $display("FAIL abort t+1: got ndDb=%b want 0101", {n, d, done, busy});
    end
    start = 1'b1; amount = 5'd1;
    tick();
    start = 1'b0; reset = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      tick();
      if (k == 4) reset = 1'b1;
      checks++;
      if ({n, d, done, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL abort t+%0d: got ndDb=%b want 0000", k, {n, d, done, busy});
      end
    end
    checks++;
    if (dime_empty !== 1'b0) begin
      errors++;
      $display("FAIL abort_stock: got dime_empty=%b want 0", dime_empty);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; refill = 1'b0; amount = '0;
    test_reset();
    test_amount3();
    test_zero();
    test_exhaust();
    test_refill();
    test_busy_start();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
